// File: rtl/parser_job_sequencer_if.sv
// Upstream program stream, result response port and parser-side signals of the
// parser job sequencer. The sequencer uses the slave view; the environment uses master.
interface parser_job_sequencer_if;
  logic [6:0]  in_char;
  logic        in_valid;
  logic        in_last;
  logic [31:0] in_x;
  logic        in_ready;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_p;
  logic [1:0]  res_status;

  logic        prs_rst;
  logic [31:0] prs_x;
  logic [6:0]  prs_char;
  logic        prs_char_valid;
  logic [31:0] prs_p;
  logic        prs_done;
  logic        prs_error;

  modport master (
    output in_char, in_valid, in_last, in_x, res_ready, prs_p, prs_done, prs_error,
    input  in_ready, res_valid, res_p, res_status, prs_rst, prs_x, prs_char, prs_char_valid
  );

  modport slave (
    input  in_char, in_valid, in_last, in_x, res_ready, prs_p, prs_done, prs_error,
    output in_ready, res_valid, res_p, res_status, prs_rst, prs_x, prs_char, prs_char_valid
  );
endinterface

// File: rtl/parser_job_sequencer.sv
// Job controller for the ASCII if/else parser: buffers one program, replays it to a
// freshly reset parser as strobed characters plus a space terminator, returns the result.
module parser_job_sequencer #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned AW      = 6,
  parameter int unsigned GAP     = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  parser_job_sequencer_if.slave  bus_io
);

  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] Full = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    StLoad, StPrep, StSendHi, StSendLo, StTermHi, StTermLo, StWait, StResp
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        ovf_q, ovf_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        in_ready_q, in_ready_d;
  logic        prs_rst_q, prs_rst_d;
  logic [31:0] prs_x_q, prs_x_d;
  logic [6:0]  prs_char_q, prs_char_d;
  logic [31:0] res_p_q, res_p_d;
  logic [1:0]  res_status_q, res_status_d;
  logic        wr_en;

  logic        beat, full, gap_done;
  logic [AW:0] rd_next;

  assign beat     = bus_io.in_valid & in_ready_q;
  // Past DEPTH stored characters every further beat belongs to an overflowed job.
  assign full     = ovf_q | (wr_ptr_q == Full);
  assign gap_done = (gap_q == GW'(GAP - 1));
  assign rd_next  = rd_ptr_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ovf_d        = ovf_q;
    gap_d        = gap_q;
    tmo_d        = tmo_q;
    prs_x_d      = prs_x_q;
    prs_char_d   = prs_char_q;
    res_p_d      = res_p_q;
    res_status_d = res_status_q;
    wr_en        = 1'b0;

    unique case (state_q)
      StLoad: begin
        if (beat) begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
          if (bus_io.in_last) begin
            prs_x_d = bus_io.in_x;
            if (full) begin
              state_d      = StResp;
              res_status_d = 2'd3;
              res_p_d      = '0;
            end else begin
              state_d = StPrep;
            end
          end
        end
      end
      StPrep: begin
        rd_ptr_d   = '0;
        prs_char_d = mem_q[0];
        state_d    = StSendHi;
      end
      StSendHi: begin
        gap_d   = '0;
        state_d = StSendLo;
      end
      StSendLo: begin
        if (gap_done) begin
          rd_ptr_d = rd_next;
          if (rd_next == wr_ptr_q) begin
            prs_char_d = 7'h20;
            state_d    = StTermHi;
          end else begin
            prs_char_d = mem_q[rd_next[AW-1:0]];
            state_d    = StSendHi;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StTermHi: begin
        gap_d   = '0;
        state_d = StTermLo;
      end
      StTermLo: begin
        if (gap_done) begin
          tmo_d   = '0;
          state_d = StWait;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StWait: begin
        tmo_d = tmo_q + 1'b1;
        if (bus_io.prs_done) begin
          res_p_d      = bus_io.prs_p;
          res_status_d = 2'd0;
          state_d      = StResp;
        end else if (tmo_d == TW'(TIMEOUT)) begin
          res_p_d      = '0;
          res_status_d = 2'd2;
          state_d      = StResp;
        end
      end
      StResp: begin
        if (bus_io.res_ready) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          ovf_d    = 1'b0;
          gap_d    = '0;
          tmo_d    = '0;
          state_d  = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase

    // A parser error overrides everything, including a simultaneous done.
    if (bus_io.prs_error &&
        (state_q inside {StSendHi, StSendLo, StTermHi, StTermLo, StWait})) begin
      res_p_d      = '0;
      res_status_d = 2'd1;
      state_d      = StResp;
    end

    in_ready_d = (state_d == StLoad);
    prs_rst_d  = (state_d == StLoad) || (state_d == StResp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StLoad;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ovf_q        <= 1'b0;
      gap_q        <= '0;
      tmo_q        <= '0;
      in_ready_q   <= 1'b0;
      prs_rst_q    <= 1'b1;
      prs_x_q      <= '0;
      prs_char_q   <= '0;
      res_p_q      <= '0;
      res_status_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ovf_q        <= ovf_d;
      gap_q        <= gap_d;
      tmo_q        <= tmo_d;
      in_ready_q   <= in_ready_d;
      prs_rst_q    <= prs_rst_d;
      prs_x_q      <= prs_x_d;
      prs_char_q   <= prs_char_d;
      res_p_q      <= res_p_d;
      res_status_q <= res_status_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus_io.in_char;
    end
  end

  assign bus_io.in_ready       = in_ready_q;
  assign bus_io.res_valid      = (state_q == StResp);
  assign bus_io.res_p          = res_p_q;
  assign bus_io.res_status     = res_status_q;
  assign bus_io.prs_rst        = prs_rst_q;
  assign bus_io.prs_x          = prs_x_q;
  assign bus_io.prs_char       = prs_char_q;
  assign bus_io.prs_char_valid = (state_q == StSendHi) || (state_q == StTermHi);

endmodule

// File: tb/tb_parser_job_sequencer.sv
// Bench for parser_job_sequencer: a behavioural parser stand-in plus a response scoreboard.
module tb_parser_job_sequencer;
  localparam int unsigned DEPTH   = 64;
  localparam int unsigned AW      = 6;
  localparam int unsigned GAP     = 1;
  localparam int unsigned TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  parser_job_sequencer_if bus ();

  parser_job_sequencer #(
    .DEPTH(DEPTH), .AW(AW), .GAP(GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  typedef struct {
    logic [1:0]  st;
    logic [31:0] p;
    int          pulses;
  } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Parser stand-in: '=' directly before a digit (not part of "<=") is an error; the
  // space after the full program finishes an if/else program with p = x>5 ? 10 : 20.
  logic [6:0]  rx [0:127];
  int          rx_cnt;
  logic        s_done, s_err;
  logic [31:0] s_p;
  int          exp_len;
  bit          exp_else;

  assign bus.prs_p     = s_p;
  assign bus.prs_done  = s_done;
  assign bus.prs_error = s_err;

  always @(posedge clk or posedge rst) begin
    if (rst || bus.prs_rst) begin
      rx_cnt <= 0;
      s_done <= 1'b0;
      s_err  <= 1'b0;
      s_p    <= '0;
    end else if (bus.prs_char_valid) begin
      rx[rx_cnt] <= bus.prs_char;
      rx_cnt     <= rx_cnt + 1;
      if (bus.prs_char >= 7'h30 && bus.prs_char <= 7'h39 && rx_cnt >= 1 &&
          rx[rx_cnt-1] == 7'h3D && !(rx_cnt >= 2 && rx[rx_cnt-2] == 7'h3C))
        s_err <= 1'b1;
      if (rx_cnt == exp_len && bus.prs_char == 7'h20 && exp_else) begin
        s_done <= 1'b1;
        s_p    <= (bus.prs_x > 32'd5) ? 32'd10 : 32'd20;
      end
    end
  end

  // Cadence / hold monitor.
  int         cyc = 0;
  int         mon_pulses = 0;
  int         last_cyc = 0;
  int         rv_cyc = 0;
  logic [6:0] last_char = '0;
  bit         have_pulse = 0;
  bit         prev_rv = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus.res_valid && !prev_rv) rv_cyc = cyc;
    prev_rv = bus.res_valid;
    if (rst || bus.prs_rst) begin
      have_pulse = 0;
    end
    if (bus.prs_char_valid) begin
      mon_pulses++;
      if (have_pulse) check_eq("cadence", cyc - last_cyc, 1 + GAP);
      last_cyc   = cyc;
      last_char  = bus.prs_char;
      have_pulse = 1;
    end else if (have_pulse && !rst && !bus.prs_rst) begin
      check_eq("char_hold", bus.prs_char, last_char);
    end
  end

  task automatic drive_prog(input string prog, input logic [31:0] x, output int acc);
    byte b;
    int  n;
    acc = 0;
    for (int i = 0; i < prog.len(); i++) begin
      b = prog[i];
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_char  = b[6:0];
      bus.in_last  = (i == prog.len() - 1);
      bus.in_x     = (i == prog.len() - 1) ? x : 32'hdead_beef;
      n = 0;
      while (!bus.in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) begin
        check_eq("in_ready_wait", bus.in_ready, 1);
        break;
      end
      acc++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run_job(input string prog, input logic [31:0] x, input logic [1:0] st,
                         input logic [31:0] p, input int pulses, input bit has_else,
                         input int hold, input bit chk_tmo);
    exp_t e;
    int   acc, n, bad;
    byte  b;
    e.st = st; e.p = p; e.pulses = pulses;
    sb_q.push_back(e);
    exp_len    = prog.len();
    exp_else   = has_else;
    mon_pulses = 0;
    check_eq("load_prs_rst", bus.prs_rst, 1);
    drive_prog(prog, x, acc);
    check_eq("beats", acc, prog.len());
    n = 0;
    while (!bus.res_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("res_valid_wait", bus.res_valid, 1);
    e = sb_q.pop_front();
    if (!bus.res_valid) return;
    check_eq("status", bus.res_status, e.st);
    check_eq("res_p", bus.res_p, e.p);
    check_eq("pulses", mon_pulses, e.pulses);
    check_eq("prs_x", bus.prs_x, x);
    check_eq("resp_prs_rst", bus.prs_rst, 1);
    if (has_else && st == 2'd0) begin
      bad = 0;
      for (int i = 0; i < prog.len(); i++) begin
        b = prog[i];
        if (rx[i] !== b[6:0]) bad++;
      end
      if (rx[prog.len()] !== 7'h20) bad++;
      check_eq("replay", bad, 0);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_valid", bus.res_valid, 1);
      check_eq("hold_p", bus.res_p, e.p);
      check_eq("hold_status", bus.res_status, e.st);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check_eq("post_valid", bus.res_valid, 0);
    check_eq("post_in_ready", bus.in_ready, 1);
    if (chk_tmo) check_eq("tmo_lat", rv_cyc - last_cyc, 1 + GAP + TIMEOUT);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string p1, p2, p3, p64, povf;
    int    acc, n;
    p1 = "if x>5 p<=10 else p<=20";
    p2 = "if x=5 p<=1 else p<=2";
    p3 = "if x<5 p<=1";
    p64 = p1;
    while (p64.len() < 64) p64 = {p64, " "};
    povf = "";
    while (povf.len() < 70) povf = {povf, "a"};

    bus.in_valid = 1'b0; bus.in_char = '0; bus.in_last = 1'b0; bus.in_x = '0;
    bus.res_ready = 1'b0;
    exp_len = 0; exp_else = 0;

    #12;
    check_eq("rst_in_ready", bus.in_ready, 0);
    check_eq("rst_res_valid", bus.res_valid, 0);
    check_eq("rst_char_valid", bus.prs_char_valid, 0);
    check_eq("rst_prs_rst", bus.prs_rst, 1);
    check_eq("rst_res_p", bus.res_p, 0);
    check_eq("rst_status", bus.res_status, 0);
    check_eq("rst_prs_x", bus.prs_x, 0);
    check_eq("rst_prs_char", bus.prs_char, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check_eq("rel_in_ready0", bus.in_ready, 0);
    @(negedge clk);
    check_eq("rel_in_ready1", bus.in_ready, 1);

    run_job(p1, 32'd7, 2'd0, 32'd10, p1.len() + 1, 1, 0, 0);
    run_job(p1, 32'd3, 2'd0, 32'd20, p1.len() + 1, 1, 0, 0);
    run_job(p1, 32'd5, 2'd0, 32'd20, p1.len() + 1, 1, 10, 0);
    run_job(p2, 32'd9, 2'd1, 32'd0, 6, 1, 0, 0);
    run_job(p3, 32'd0, 2'd2, 32'd0, p3.len() + 1, 0, 0, 1);
    run_job(povf, 32'd4, 2'd3, 32'd0, 0, 0, 0, 0);
    run_job(p64, 32'd7, 2'd0, 32'd10, 65, 1, 0, 0);

    // Reset in the middle of SEND_LO: no response, parser back in reset.
    exp_len = p1.len(); exp_else = 1; mon_pulses = 0;
    drive_prog(p1, 32'd7, acc);
    n = 0;
    while (mon_pulses < 3 && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (!bus.prs_char_valid && n < 10) begin @(negedge clk); n++; end
    check_eq("mid_hi", bus.prs_char_valid, 1);
    @(negedge clk);
    check_eq("mid_lo", bus.prs_char_valid, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_prs_rst", bus.prs_rst, 1);
    check_eq("mid_char_valid", bus.prs_char_valid, 0);
    check_eq("mid_res_valid", bus.res_valid, 0);
    check_eq("mid_prs_char", bus.prs_char, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_in_ready", bus.in_ready, 1);

    run_job(p1, 32'd8, 2'd0, 32'd10, p1.len() + 1, 1, 0, 0);

    check_eq("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
